// File: rtl/awgn_burst_ctrl.sv
// awgn_burst_ctrl: seeds, resets and windows one AWGN generator, then scales, saturates and buffers each burst
module awgn_burst_ctrl #(
  parameter int SEED_CYC  = 2,
  parameter int WARMUP    = 16,
  parameter int DEPTH     = 4,
  parameter int GAIN_FRAC = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_seed_we,
  input  logic [2:0]   cfg_seed_idx,
  input  logic [31:0]  cfg_seed_data,
  output logic [191:0] gen_seed,
  output logic         gen_rst,
  input  logic [15:0]  gen_sample,
  input  logic         start,
  input  logic         abort,
  input  logic [15:0]  burst_len,
  input  logic [7:0]   gain,
  output logic         busy,
  output logic         done,
  output logic [15:0]  out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [15:0]  drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [15:0] SEED_LAST = 16'(SEED_CYC - 1);
  localparam logic [15:0] WARM_LAST = 16'(WARMUP - 1);
  localparam logic [AW:0] FULL_NUM = (AW + 1)'(DEPTH);
  typedef enum logic [2:0] {IDLE, SEED, WARM, RUN, DRAIN} state_t;
  state_t r_state, w_next;
  logic [15:0] r_cnt, r_len, r_drop;
  logic [7:0] r_gain;
  logic [31:0] r_seed [6];
  logic [15:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_num;
  logic w_empty, w_full, w_pop, w_take, w_push, w_flush, w_start;
  logic signed [24:0] w_prod, w_shift;
  logic [15:0] w_scaled;
  assign w_empty = r_num == '0;
  assign w_full = r_num == FULL_NUM;
  assign w_flush = abort && r_state != IDLE;
  assign w_start = start && r_state == IDLE && burst_len != 16'd0;
  assign w_take = r_state == RUN && !abort;
  assign w_pop = !w_empty && out_ready;
  assign w_push = w_take && (!w_full || w_pop);
  assign w_prod = $signed(gen_sample) * $signed({1'b0, r_gain});
  assign w_shift = w_prod >>> GAIN_FRAC;
  assign w_scaled = w_shift > 25'sd32767 ? 16'h7FFF : w_shift < -25'sd32768 ? 16'h8000 : w_shift[15:0];
  assign gen_seed = {r_seed[5], r_seed[4], r_seed[3], r_seed[2], r_seed[1], r_seed[0]};
  assign gen_rst = !(r_state == WARM || r_state == RUN);
  assign busy = r_state != IDLE;
  assign done = r_state == DRAIN && w_empty && !abort;
  assign out_valid = !w_empty;
  assign out_data = w_empty ? '0 : r_mem[r_rd];
  assign drop_cnt = r_drop;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = w_start ? SEED : IDLE;
      SEED:    w_next = r_cnt == SEED_LAST ? WARM : SEED;
      WARM:    w_next = r_cnt == WARM_LAST ? RUN : WARM;
      RUN:     w_next = r_cnt + 16'd1 == r_len ? DRAIN : RUN;
      DRAIN:   w_next = w_empty ? IDLE : DRAIN;
      default: w_next = IDLE;
    endcase
    if (w_flush) w_next = IDLE;
  end
  // one counter serves every timed state; it restarts on each state change
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_len <= '0;
      r_gain <= '0;
      r_drop <= '0;
      r_wr <= '0;
      r_rd <= '0;
      r_num <= '0;
      for (int i = 0; i < 6; i++) r_seed[i] <= '0;
    end else begin
      r_state <= w_next;
      r_cnt <= w_next != r_state ? '0 : r_cnt + 16'd1;
      if (r_state == IDLE && cfg_seed_we && cfg_seed_idx < 3'd6) r_seed[cfg_seed_idx] <= cfg_seed_data;
      if (w_start) begin
        r_len <= burst_len;
        r_gain <= gain;
        r_drop <= '0;
      end else if (w_take && !w_push && r_drop != 16'hFFFF) begin
        r_drop <= r_drop + 16'd1;
      end
      if (w_flush) begin
        r_wr <= '0;
        r_rd <= '0;
        r_num <= '0;
      end else begin
        if (w_push) r_wr <= r_wr + 1'b1;
        if (w_pop) r_rd <= r_rd + 1'b1;
        r_num <= r_num + (AW + 1)'(w_push) - (AW + 1)'(w_pop);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= w_scaled;
  end
endmodule
